// File: rtl/sseg_demux.sv
// Recovers 4-digit frames from a multiplexed active-low 7-segment bus.
// Optional frame counter output: define SSEG_DEMUX_FRAME_CNT_EN.
module sseg_demux #(
  parameter int MIN_DWELL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sseg,
  input  logic [3:0] an,
  input  logic       dp,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] dp_pos,
  output logic       dp_seen,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       seq_err,
  output logic       an_err
`ifdef SSEG_DEMUX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [7:0] MD = 8'(MIN_DWELL);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } state_e;

  state_e     state_q;
  logic [6:0] sseg_q;
  logic [3:0] an_q;
  logic       dp_q;
  logic [1:0] pos_q;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] buf0_q, buf1_q, buf2_q;
  logic [2:0] dpb_q;
  logic       bad_q;

  logic       an_vld, an_ill, chg, cap, in_col, hit, pub;
  logic [1:0] an_pos, dp_lo;
  logic [3:0] cur_dig, dpv;
  logic       cur_bad, cur_dp;

  function automatic logic [3:0] dec(input logic [6:0] s);
    case (s)
      7'b0000001: dec = 4'd0;
      7'b1001111: dec = 4'd1;
      7'b0010010: dec = 4'd2;
      7'b0000110: dec = 4'd3;
      7'b1001100: dec = 4'd4;
      7'b0100100: dec = 4'd5;
      7'b0100000: dec = 4'd6;
      7'b0001111: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0001100: dec = 4'd9;
      default:    dec = 4'hF;
    endcase
  endfunction

  always_comb begin
    an_vld = 1'b0;
    an_pos = 2'd0;
    unique case (an_q)
      4'b1110: begin an_vld = 1'b1; an_pos = 2'd0; end
      4'b1101: begin an_vld = 1'b1; an_pos = 2'd1; end
      4'b1011: begin an_vld = 1'b1; an_pos = 2'd2; end
      4'b0111: begin an_vld = 1'b1; an_pos = 2'd3; end
      default: ;
    endcase
    an_ill = !an_vld && (an_q != 4'hF);
    // a zero count means the previous cycle was not this position
    chg = (pos_q != an_pos) || (dwell_q == 8'd0);
    if (!an_vld)          dwell_d = 8'd0;
    else if (chg)         dwell_d = 8'd1;
    else if (dwell_q == MD) dwell_d = dwell_q;
    else                  dwell_d = dwell_q + 8'd1;
    cap = an_vld && (dwell_d == MD)
        && (chg || (dwell_q != MD));
    in_col = (state_q != HUNT);
    hit = cap && in_col && (an_pos == state_q);
    pub = hit && (state_q == COL3);
    cur_dig = dec(sseg_q);
    cur_bad = (cur_dig == 4'hF);
    cur_dp = ~dp_q;
    dpv = {cur_dp, dpb_q};
    dp_lo = 2'd3;
    if (dpv[2]) dp_lo = 2'd2;
    if (dpv[1]) dp_lo = 2'd1;
    if (dpv[0]) dp_lo = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sseg_q      <= 7'h7F;
      an_q        <= 4'hF;
      dp_q        <= 1'b1;
      pos_q       <= 2'd0;
      dwell_q     <= 8'd0;
      state_q     <= HUNT;
      buf0_q      <= 4'h0;
      buf1_q      <= 4'h0;
      buf2_q      <= 4'h0;
      dpb_q       <= 3'b000;
      bad_q       <= 1'b0;
      digit0      <= 4'h0;
      digit1      <= 4'h0;
      digit2      <= 4'h0;
      digit3      <= 4'h0;
      dp_pos      <= 2'd0;
      dp_seen     <= 1'b0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      seq_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      sseg_q      <= sseg;
      an_q        <= an;
      dp_q        <= dp;
      dwell_q     <= dwell_d;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      an_err      <= 1'b0;
      if (an_vld) pos_q <= an_pos;
      if (an_ill) begin
        an_err  <= 1'b1;
        state_q <= HUNT;
      end else if (cap) begin
        if (in_col && !hit) seq_err <= 1'b1;
        if (an_pos == 2'd0) begin
          buf0_q  <= cur_dig;
          dpb_q   <= {2'b00, cur_dp};
          bad_q   <= cur_bad;
          state_q <= COL1;
        end else if (pub) begin
          digit0      <= buf0_q;
          digit1      <= buf1_q;
          digit2      <= buf2_q;
          digit3      <= cur_dig;
          dp_pos      <= dp_lo;
          dp_seen     <= |dpv;
          seg_err     <= bad_q | cur_bad;
          frame_valid <= 1'b1;
          state_q     <= HUNT;
        end else if (hit && state_q == COL1) begin
          buf1_q   <= cur_dig;
          dpb_q[1] <= cur_dp;
          bad_q    <= bad_q | cur_bad;
          state_q  <= COL2;
        end else if (hit) begin
          buf2_q   <= cur_dig;
          dpb_q[2] <= cur_dp;
          bad_q    <= bad_q | cur_bad;
          state_q  <= COL3;
        end else if (in_col) begin
          state_q <= HUNT;
        end
      end
    end
  end

`ifdef SSEG_DEMUX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   frame_cnt <= 16'h0;
    else if (pub) frame_cnt <= frame_cnt + 16'h1;
  end
`endif

endmodule

// File: doc/sseg_demux.md
SSEG_DEMUX -- requirements
Module: sseg_demux

Interface
REQ-001 SHALL have parameter MIN_DWELL, default 1, range 1..255: consecutive registered cycles an anode pattern must hold before capture.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-004 SHALL have port sseg, input, 7: segment bus {a,b,c,d,e,f,g}, active-low.
REQ-005 SHALL have port an, input, 4: anode selects, active-low; an[i]=0 selects position i.
REQ-006 SHALL have port dp, input, 1: decimal point, active-low.
REQ-007 SHALL have ports digit0..digit3, output, 4 each: decoded value per position; 4'hF means undecodable.
REQ-008 SHALL have port dp_pos, output, 2: position whose dp was low in the last published frame.
REQ-009 SHALL have port dp_seen, output, 1: high when dp_pos is meaningful.
REQ-010 SHALL have port frame_valid, output, 1: one-cycle pulse when digit0..3, dp_pos, dp_seen and seg_err update.
REQ-011 SHALL have port seg_err, output, 1: last published frame contained an undecodable pattern.
REQ-012 SHALL have ports seq_err and an_err, output, 1 each: one-cycle error pulses.

Function
REQ-013 SHALL register sseg, an and dp on every edge before any other use.
REQ-014 SHALL classify registered an: exactly one zero = valid position; 4'b1111 = blank; otherwise illegal.
REQ-015 SHALL keep a dwell counter: cleared on blank, illegal or position change; incremented (saturating at MIN_DWELL) while the position holds.
REQ-016 SHALL capture sseg and dp for a position exactly once per dwell, when the counter reaches MIN_DWELL; further holding SHALL NOT recapture.
REQ-017 SHALL decode: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9; any other pattern = 4'hF and marks the frame bad.
REQ-018 SHALL run a frame FSM with states HUNT and COLLECT(expected index 1..3).
REQ-019 SHALL, in HUNT, go to COLLECT(1) on capture of position 0 and ignore captures of positions 1..3.
REQ-020 SHALL, in COLLECT(n), advance to COLLECT(n+1) on capture of position n; on capture of position 3 in COLLECT(3) publish the frame and return to HUNT.
REQ-021 SHALL, in COLLECT, on capture of an unexpected position pulse seq_err and discard the partial frame; if that position is 0 go to COLLECT(1), else HUNT.
REQ-022 SHALL, on an illegal an, pulse an_err, discard the partial frame and go to HUNT; blank SHALL NOT change FSM state.
REQ-023 SHALL publish: update all frame outputs and pulse frame_valid on the same edge; outputs hold until the next publish.
REQ-024 SHALL set dp_pos to the lowest position with dp low; dp_seen=0 if none.
REQ-025 SHALL produce frame_valid at edge k+MIN_DWELL, where k is the edge that first registers position 3 of a complete frame.

Reset
REQ-026 SHALL, while reset=0, force digit0..3=4'h0, dp_pos=0, dp_seen=0, frame_valid=0, seg_err=0, seq_err=0, an_err=0, dwell=0 and FSM=HUNT.
REQ-027 SHALL discard any partial frame on reset assertion; the first frame after release SHALL start at position 0.

Configuration
REQ-028 SHALL, with SSEG_DEMUX_FRAME_CNT_EN defined, add output frame_cnt[15:0] that resets to 0, increments on each frame_valid and wraps 16'hFFFF->0.
REQ-029 SHALL, without SSEG_DEMUX_FRAME_CNT_EN, omit frame_cnt and its logic entirely.

Verification
REQ-030 SHALL check: MIN_DWELL=1, an cycles 1110,1101,1011,0111 every clock with sseg 0000001,1001111,0010010,0001100 and dp low only on 1011 -> frame_valid once per 4 cycles, digits 0,1,2,9, dp_pos=2, dp_seen=1, seg_err=0.
REQ-031 SHALL check: MIN_DWELL=3, each anode held 5 cycles -> one capture per position, frame_valid once per 20 cycles; hold 2 cycles -> no frame_valid.
REQ-032 SHALL check: sseg 1111111 on position 1 -> digit1=4'hF, seg_err=1 with frame_valid.
REQ-033 SHALL check: order 0,2 -> seq_err pulse, no publish; subsequent clean 0,1,2,3 -> publishes.
REQ-034 SHALL check: an=1100 mid-frame -> an_err pulse, frame discarded; an=1111 between positions -> no error, frame publishes.
REQ-035 SHALL check: reset low after positions 0,1 captured -> outputs at reset values; after release, positions 2,3 alone -> no publish.
